sub_bytes_seq: RTL and testbench

Parametrised, time-multiplexed AES SubBytes engine: substitutes every byte of an `NWords`-word state through `LANES` shared S-box instances over several cycles, with valid/ready handshakes on both sides. It replaces the fully parallel, purely combinational SubBytes stage wherever S-box area is traded for latency, for example in iterative round datapaths and key expansion. It optionally supports inverse substitution for the decrypt path.

---
 rtl/sub_bytes_seq.sv | 141 ++++++++++++++
 tb/tb_sub_bytes_seq.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_seq.sv
// Time-multiplexed AES SubBytes: LANES shared S-boxes walk an NWords-word state over BEATS cycles.
// Optional inverse substitution per lane is compiled in when SBYTES_INV_EN is defined.
module sub_bytes_seq #(
    parameter int NWords = 4,
    parameter int LANES  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NWords*32-1:0] bytes_in,
    input  logic                 inv,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NWords*32-1:0] bytes_out,
    output logic                 busy
);
    localparam int NBYTES = 4 * NWords;
    localparam int BEATS  = NBYTES / LANES;
    localparam int CW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IW     = $clog2(NBYTES);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    if (LANES < 1 || LANES > NBYTES || (NBYTES % LANES) != 0) begin : g_bad_lanes
        $error("sub_bytes_seq: LANES must divide 4*NWords");
    end

    localparam logic [0:255][7:0] SBOX_FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state_q;
    logic [CW-1:0]          beat_q;
    logic [NBYTES-1:0][7:0] data_q;
    logic [NBYTES-1:0][7:0] data_d;
    logic                   out_valid_q;
    logic                   busy_q;
    logic [LANES-1:0][7:0]  lane_in;
    logic [LANES-1:0][7:0]  lane_out;
    logic                   accept;

    assign in_ready  = !rst && ((state_q == IDLE) || (state_q == DONE && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign bytes_out = data_q;

`ifdef SBYTES_INV_EN
    localparam logic [0:255][7:0] SBOX_INV = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    // The direction is captured at acceptance so a toggling inv input cannot split a transaction.
    logic inv_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            inv_q <= 1'b0;
        end else if (accept) begin
            inv_q <= inv;
        end
    end
`else
    logic unused_inv;
    assign unused_inv = inv;
`endif

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign lane_in[gi] = data_q[IW'(int'(beat_q) * LANES + gi)];
`ifdef SBYTES_INV_EN
        assign lane_out[gi] = inv_q ? SBOX_INV[lane_in[gi]] : SBOX_FWD[lane_in[gi]];
`else
        assign lane_out[gi] = SBOX_FWD[lane_in[gi]];
`endif
    end

    // Byte gi belongs to beat gi/LANES and is served by lane gi%LANES.
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_wb
        assign data_d[gi] = (beat_q == CW'(gi / LANES)) ? lane_out[gi % LANES] : data_q[gi];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            data_q      <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        data_q  <= bytes_in;
                        beat_q  <= '0;
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    data_q <= data_d;
                    if (beat_q == LAST_BEAT) begin
                        beat_q      <= '0;
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        beat_q <= beat_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (accept) begin
                            data_q  <= bytes_in;
                            beat_q  <= '0;
                            state_q <= RUN;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sub_bytes_seq.sv
// Bench for sub_bytes_seq: four instances (LANES 4/1/2/8), a cycle-level reference model
// with S-box tables derived from GF(2^8) arithmetic, plus directed literal vectors.
module tb_sub_bytes_seq;
    localparam int NI = 4;
    localparam int BT [NI] = '{4, 16, 8, 1};
    localparam int NB [NI] = '{16, 16, 16, 8};
`ifdef SBYTES_INV_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0] rst_a, iv, inv_a, ordy, ir, ov, bsy;
    logic [127:0]  din  [NI];
    logic [127:0]  dout [NI];

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int NW = (gi == 3) ? 2 : 4;
        localparam int LN = (gi == 0) ? 4 : (gi == 1) ? 1 : (gi == 2) ? 2 : 8;
        logic [NW*32-1:0] o;
        sub_bytes_seq #(.NWords(NW), .LANES(LN)) u_dut (
            .clk       (clk),
            .rst       (rst_a[gi]),
            .in_valid  (iv[gi]),
            .in_ready  (ir[gi]),
            .bytes_in  (din[gi][NW*32-1:0]),
            .inv       (inv_a[gi]),
            .out_valid (ov[gi]),
            .out_ready (ordy[gi]),
            .bytes_out (o),
            .busy      (bsy[gi])
        );
        assign dout[gi] = 128'(o);
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h, required %h", name, act, exp);
        end
    endtask

    // Reference S-boxes from first principles: multiplicative inverse then affine map.
    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(logic [7:0] x);
        if (x == 8'h00) return 8'h00;
        for (int y = 1; y < 256; y++)
            if (gmul(x, 8'(y)) == 8'h01) return 8'(y);
        return 8'h00;
    endfunction

    function automatic logic [7:0] rotl(logic [7:0] b, int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [127:0] model_sub(logic [127:0] d, logic v, int nb);
        logic [127:0] r = '0;
        for (int b = 0; b < nb; b++)
            r[8*b +: 8] = (v && INV_EN) ? inv_tab[d[8*b +: 8]] : fwd_tab[d[8*b +: 8]];
        return r;
    endfunction

    // Model: cycles left until the result appears, whether a result is on offer, and its value.
    int           m_left [NI];
    bit           m_ov   [NI];
    logic [127:0] m_out  [NI];
    logic [127:0] m_pend [NI];
    bit           en = 1'b0;

    always @(negedge clk) begin
        if (en) begin
            for (int i = 0; i < NI; i++) begin
                check($sformatf("out_valid[%0d]", i), 128'(ov[i]), 128'(m_ov[i]));
                check($sformatf("busy[%0d]", i), 128'(bsy[i]), 128'(m_ov[i] || m_left[i] > 0));
                check($sformatf("in_ready[%0d]", i), 128'(ir[i]),
                      128'(!rst_a[i] && ((!m_ov[i] && m_left[i] == 0) || (m_ov[i] && ordy[i]))));
                if (m_left[i] == 0)
                    check($sformatf("bytes_out[%0d]", i), dout[i], m_out[i]);
                // advance the model across the coming rising edge
                if (rst_a[i]) begin
                    m_left[i] = 0;
                    m_ov[i]   = 1'b0;
                    m_out[i]  = '0;
                end else if (m_ov[i]) begin
                    if (ordy[i]) begin
                        m_ov[i] = 1'b0;
                        if (iv[i]) begin
                            m_pend[i] = model_sub(din[i], inv_a[i], NB[i]);
                            m_left[i] = BT[i];
                        end
                    end
                end else if (m_left[i] > 0) begin
                    m_left[i]--;
                    if (m_left[i] == 0) begin
                        m_ov[i]  = 1'b1;
                        m_out[i] = m_pend[i];
                    end
                end else if (iv[i]) begin
                    m_pend[i] = model_sub(din[i], inv_a[i], NB[i]);
                    m_left[i] = BT[i];
                end
            end
        end
    end

    task automatic send(input int i, input logic [127:0] d, input logic v);
        bit ok = 1'b0;
        @(posedge clk);
        #1;
        din[i]   = d;
        inv_a[i] = v;
        iv[i]    = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (ir[i]) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        iv[i] = 1'b0;
        check($sformatf("accept[%0d]", i), 128'(ok), 128'(1));
    endtask

    // Counts rising edges from the acceptance edge until out_valid is seen.
    task automatic wait_out(input int i, output logic [127:0] d, output int lat);
        lat = -1;
        d   = 'x;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (ov[i]) begin
                lat = c;
                d   = dout[i];
                break;
            end
        end
    endtask

    bit rdone = 1'b0;

    initial begin
        logic [127:0] r;
        int           c;
        rst_a = '1;
        iv    = '0;
        inv_a = '0;
        ordy  = '1;
        for (int i = 0; i < NI; i++) begin
            din[i]    = '0;
            m_out[i]  = '0;
            m_pend[i] = '0;
            m_left[i] = 0;
            m_ov[i]   = 1'b0;
        end
        for (int x = 0; x < 256; x++) begin
            logic [7:0] b;
            b = ginv(8'(x));
            fwd_tab[x] = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = 8'(x);

        check("model_fwd_00", 128'(fwd_tab[8'h00]), 128'h63);
        check("model_fwd_01", 128'(fwd_tab[8'h01]), 128'h7c);
        check("model_fwd_ff", 128'(fwd_tab[8'hff]), 128'h16);
        check("model_fwd_53", 128'(fwd_tab[8'h53]), 128'hed);
        check("model_inv_63", 128'(inv_tab[8'h63]), 128'h00);

        @(posedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        rst_a = '0;

        // FIPS-197 round-1 SubBytes vector through the default configuration
        send(0, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0);
        wait_out(0, r, c);
        check("fips_fwd_data", r, 128'hd42711aee0bf98f1b8b45de51e415230);
        check("fips_fwd_latency", 128'(c), 128'(4));

        // one lane: sixteen beats
        send(1, '0, 1'b0);
        wait_out(1, r, c);
        check("lane1_zero_data", r, {16{8'h63}});
        check("lane1_latency", 128'(c), 128'(16));

        // inverse request: undone when the inverse tables exist, forward otherwise
        send(0, 128'hd42711aee0bf98f1b8b45de51e415230, 1'b1);
        wait_out(0, r, c);
        check("inv_data", r, INV_EN ? 128'h193de3bea0f4e22b9ac68d2ae9f84808
                                    : 128'h48cc82e4e10846a16c8d4cd972830004);

        // backpressure in DONE, then hand-off straight into a new transaction
        @(posedge clk);
        #1;
        ordy[0] = 1'b0;
        send(0, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0);
        wait_out(0, r, c);
        check("bp_latency", 128'(c), 128'(4));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid_held", 128'(ov[0]), 128'(1));
            check("bp_data_held", dout[0], 128'hd42711aee0bf98f1b8b45de51e415230);
        end
        @(posedge clk);
        #1;
        ordy[0]  = 1'b1;
        din[0]   = {16{8'h01}};
        inv_a[0] = 1'b0;
        iv[0]    = 1'b1;
        @(negedge clk);
        check("bp_in_ready", 128'(ir[0]), 128'(1));
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        @(negedge clk);
        check("bp_next_valid", 128'(ov[0]), 128'(0));
        check("bp_next_busy", 128'(bsy[0]), 128'(1));
        wait_out(0, r, c);
        check("bp_next_data", r, {16{8'h7c}});
        check("bp_next_latency", 128'(c), 128'(3));

        // reset at beat 3 of a two-lane run
        send(2, {16{8'h5a}}, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_a[2] = 1'b1;
        @(posedge clk);
        #1;
        rst_a[2] = 1'b0;
        @(negedge clk);
        check("rst_valid", 128'(ov[2]), 128'(0));
        check("rst_busy", 128'(bsy[2]), 128'(0));
        check("rst_data", dout[2], 128'h0);
        send(2, {16{8'hff}}, 1'b0);
        wait_out(2, r, c);
        check("post_rst_data", r, {16{8'h16}});
        check("post_rst_latency", 128'(c), 128'(8));

        // all lanes in one beat on a two-word state
        send(3, 128'({8{8'h01}}), 1'b0);
        wait_out(3, r, c);
        check("beat1_data", r, 128'({8{8'h7c}}));
        check("beat1_latency", 128'(c), 128'(1));

        // random states and directions under random backpressure
        fork
            begin
                while (!rdone) begin
                    @(posedge clk);
                    #1;
                    ordy[0] = 1'($urandom_range(0, 1));
                end
            end
            begin
                for (int k = 0; k < 6; k++)
                    send(0, {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));
                rdone = 1'b1;
            end
        join
        @(posedge clk);
        #1;
        ordy[0] = 1'b1;
        repeat (25) @(posedge clk);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end
endmodule
